// File: rtl/sdram_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module      : sdram_arb_pkg
// Description : Shared definitions for the SDRAM page arbiter. It holds the
//               FSM state encoding, the requester count, the pointer width,
//               the default watchdog limit and small index helpers.
// Revision    : 1.0 - initial release
// ============================================================================
package sdram_arb_pkg;

  localparam int NUM_REQ            = 2;
  localparam int REQ_IDX_BITS       = 1;
  localparam int PTR_BITS           = 14;
  localparam int DEF_TIMEOUT_CYCLES = 4096;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ACKWAIT = 2'd1,
    ST_BUSY    = 2'd2
  } arb_state_t;

  // One-hot to binary index. Returns 0 for an all-zero vector.
  function automatic logic [REQ_IDX_BITS-1:0] oh2idx(input logic [NUM_REQ-1:0] oh);
    logic [REQ_IDX_BITS-1:0] idx;
    idx = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (oh[i]) idx = REQ_IDX_BITS'(i);
    end
    return idx;
  endfunction

  // Requester index that sits k places after 'last' in round-robin order.
  function automatic logic [REQ_IDX_BITS-1:0] rr_slot(input logic [REQ_IDX_BITS-1:0] last,
                                                      input int k);
    return REQ_IDX_BITS'((int'(last) + k) % NUM_REQ);
  endfunction

endpackage
`default_nettype wire

// File: rtl/sdram_arb_rr.sv
`default_nettype none
// ============================================================================
// Module      : sdram_arb_rr
// Description : Combinational round-robin picker. The requester that follows
//               the last-granted one in circular order is checked first, so
//               the last-granted requester always has the lowest priority.
// Ports       : i_req   - per-requester request (any direction)
//               i_last  - one-hot last-granted requester
//               o_pick  - one-hot selected requester, zero if no request
// Revision    : 1.0 - initial release
// ============================================================================
module sdram_arb_rr
  import sdram_arb_pkg::*;
(
  input  logic [NUM_REQ-1:0] i_req,
  input  logic [NUM_REQ-1:0] i_last,
  output logic [NUM_REQ-1:0] o_pick
);

  logic [REQ_IDX_BITS-1:0] w_last_idx;
  logic [REQ_IDX_BITS-1:0] w_slot;
  logic                    w_found;

  assign w_last_idx = oh2idx(i_last);

  // Walk the requesters starting just after the last grant; the first one
  // found with a pending request wins. k == NUM_REQ lands on the last
  // granted requester itself, giving it the final (lowest) chance.
  always_comb begin
    o_pick  = '0;
    w_found = 1'b0;
    w_slot  = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      w_slot = rr_slot(w_last_idx, k);
      if (!w_found && i_req[w_slot]) begin
        o_pick[w_slot] = 1'b1;
        w_found        = 1'b1;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/sdram_page_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : sdram_page_arbiter
// Description : Arbitrates two requesters for an SDRAM controller that moves
//               whole pages. Each requester owns a write and a read page
//               pointer; a granted transfer presents {requester, pointer} as
//               the row address and advances the pointer on controller ack.
//               Optional macro ARB_WATCHDOG_EN adds a transfer watchdog that
//               aborts a stuck transfer and sets a sticky fault flag.
// Ports       : clk, reset            - clock, synchronous active-high reset
//               i_req_write/i_req_read- per-requester page requests (level)
//               o_grant, o_grant_write- one-hot owner and its direction
//               o_xfer_done           - completion pulse to the owner
//               o_cmd_pagewrite/read  - controller command (held until ack)
//               i_cmd_ack/i_cmd_done  - controller acknowledge / completion
//               o_rowaddr             - page address to the controller
//               o_wd_fault            - sticky watchdog fault
// Revision    : 1.0 - initial release
// ============================================================================
module sdram_page_arbiter
  import sdram_arb_pkg::*;
#(
  parameter int ROW_BITS       = 15,
  parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [NUM_REQ-1:0]  i_req_write,
  input  logic [NUM_REQ-1:0]  i_req_read,
  output logic [NUM_REQ-1:0]  o_grant,
  output logic                o_grant_write,
  output logic [NUM_REQ-1:0]  o_xfer_done,
  output logic                o_cmd_pagewrite,
  output logic                o_cmd_pageread,
  input  logic                i_cmd_ack,
  input  logic                i_cmd_done,
  output logic [ROW_BITS-1:0] o_rowaddr,
  output logic                o_wd_fault
);

  // Elaboration-time sanity: the row address is exactly {index, pointer}.
  if (ROW_BITS != PTR_BITS + REQ_IDX_BITS) begin : g_row_bits_check
    $error("ROW_BITS must equal PTR_BITS + REQ_IDX_BITS");
  end
  if (TIMEOUT_CYCLES < 2) begin : g_timeout_check
    $error("TIMEOUT_CYCLES must be at least 2");
  end

  arb_state_t              r_state;
  arb_state_t              w_state_next;

  logic [NUM_REQ-1:0]      r_grant;
  logic [NUM_REQ-1:0]      r_last;
  logic [REQ_IDX_BITS-1:0] r_owner;
  logic                    r_grant_write;
  logic [NUM_REQ-1:0]      r_xfer_done;
  logic [ROW_BITS-1:0]     r_rowaddr;
  logic [PTR_BITS-1:0]     r_wptr [NUM_REQ];
  logic [PTR_BITS-1:0]     r_rptr [NUM_REQ];

  logic [NUM_REQ-1:0]      w_any_req;
  logic [NUM_REQ-1:0]      w_pick;
  logic [REQ_IDX_BITS-1:0] w_pick_idx;
  logic                    w_pick_write;
  logic [PTR_BITS-1:0]     w_pick_ptr;

  logic                    w_start;    // IDLE -> ACKWAIT, latch a new grant
  logic                    w_ack;      // ack accepted, advance owner pointer
  logic                    w_finish;   // normal completion, pulse xfer_done
  logic                    w_timeout;  // watchdog abort
  logic                    w_wd_expire;

  // --------------------------------------------------------------------------
  // Requester selection
  // --------------------------------------------------------------------------
  assign w_any_req = i_req_write | i_req_read;

  sdram_arb_rr u_rr (
    .i_req  (w_any_req),
    .i_last (r_last),
    .o_pick (w_pick)
  );

  assign w_pick_idx   = oh2idx(w_pick);
  // Write beats read inside the chosen requester.
  assign w_pick_write = i_req_write[w_pick_idx];
  assign w_pick_ptr   = w_pick_write ? r_wptr[w_pick_idx] : r_rptr[w_pick_idx];

  // --------------------------------------------------------------------------
  // FSM: state register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) r_state <= ST_IDLE;
    else       r_state <= w_state_next;
  end

  // --------------------------------------------------------------------------
  // FSM: next state and event decode
  // --------------------------------------------------------------------------
  always_comb begin
    w_state_next = r_state;
    w_start      = 1'b0;
    w_ack        = 1'b0;
    w_finish     = 1'b0;
    w_timeout    = 1'b0;
    case (r_state)
      ST_IDLE: begin
        // cmd_ack / cmd_done are meaningless here and deliberately ignored.
        if (|w_any_req) begin
          w_start      = 1'b1;
          w_state_next = ST_ACKWAIT;
        end
      end
      ST_ACKWAIT: begin
        // A done without ack cannot belong to this command, so it is dropped.
        if (i_cmd_ack) begin
          w_ack = 1'b1;
          if (i_cmd_done) begin
            w_finish     = 1'b1;
            w_state_next = ST_IDLE;
          end else begin
            w_state_next = ST_BUSY;
          end
        end
      end
      ST_BUSY: begin
        if (i_cmd_done) begin
          w_finish     = 1'b1;
          w_state_next = ST_IDLE;
        end
      end
      default: w_state_next = ST_IDLE;
    endcase

    // Abort overrides completion; an ack seen on the final cycle still
    // advances the pointer because the controller did take the command.
    if (w_wd_expire) begin
      w_finish     = 1'b0;
      w_timeout    = 1'b1;
      w_state_next = ST_IDLE;
    end
  end

  // --------------------------------------------------------------------------
  // Grant, address and pointer datapath
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      r_grant       <= '0;
      // Pretend the highest requester was served last so requester 0 leads.
      r_last        <= {1'b1, {(NUM_REQ-1){1'b0}}};
      r_owner       <= '0;
      r_grant_write <= 1'b0;
      r_xfer_done   <= '0;
      r_rowaddr     <= '0;
      for (int i = 0; i < NUM_REQ; i++) begin
        r_wptr[i] <= '0;
        r_rptr[i] <= '0;
      end
    end else begin
      r_xfer_done <= '0;

      if (w_start) begin
        r_grant       <= w_pick;
        r_last        <= w_pick;
        r_owner       <= w_pick_idx;
        r_grant_write <= w_pick_write;
        r_rowaddr     <= ROW_BITS'({w_pick_idx, w_pick_ptr});
      end

      // Pointers wrap naturally at 2^PTR_BITS.
      if (w_ack) begin
        if (r_grant_write) r_wptr[r_owner] <= r_wptr[r_owner] + PTR_BITS'(1);
        else               r_rptr[r_owner] <= r_rptr[r_owner] + PTR_BITS'(1);
      end

      if (w_finish) begin
        r_xfer_done   <= r_grant;
        r_grant       <= '0;
        r_grant_write <= 1'b0;
      end

      if (w_timeout) begin
        r_grant       <= '0;
        r_grant_write <= 1'b0;
      end
    end
  end

  // --------------------------------------------------------------------------
  // Optional transfer watchdog
  // --------------------------------------------------------------------------
`ifdef ARB_WATCHDOG_EN
  localparam int WD_BITS = $clog2(TIMEOUT_CYCLES + 1);

  logic [WD_BITS-1:0] r_wd_cnt;
  logic               r_wd_fault;

  // The counter holds the number of ACKWAIT/BUSY cycles already elapsed;
  // expiry fires on the cycle that would make it reach TIMEOUT_CYCLES.
  assign w_wd_expire = (r_state != ST_IDLE) &&
                       (r_wd_cnt == WD_BITS'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk) begin
    if (reset) begin
      r_wd_cnt   <= '0;
      r_wd_fault <= 1'b0;
    end else begin
      if (w_start)                 r_wd_cnt <= '0;
      else if (r_state != ST_IDLE) r_wd_cnt <= r_wd_cnt + WD_BITS'(1);
      if (w_timeout)               r_wd_fault <= 1'b1;
    end
  end

  assign o_wd_fault = r_wd_fault;
`else
  assign w_wd_expire = 1'b0;
  assign o_wd_fault  = 1'b0;
`endif

  // --------------------------------------------------------------------------
  // Outputs
  // --------------------------------------------------------------------------
  // Commands are a pure decode of ACKWAIT so they drop in the cycle after ack.
  assign o_cmd_pagewrite = (r_state == ST_ACKWAIT) &&  r_grant_write;
  assign o_cmd_pageread  = (r_state == ST_ACKWAIT) && !r_grant_write;
  assign o_grant         = r_grant;
  assign o_grant_write   = r_grant_write;
  assign o_xfer_done     = r_xfer_done;
  assign o_rowaddr       = r_rowaddr;

endmodule
`default_nettype wire
